// File: rtl/page_walker_if.sv
// PTE read port between the page walker (master) and the memory subsystem (slave).
// One request in flight at a time; the response carries a full 64-bit PTE.
interface page_walker_if #(
  parameter int SADDR = 64
);
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [SADDR-1:0] mem_req_addr;
  logic             mem_resp_valid;
  logic [63:0]      mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );
endinterface

// File: rtl/page_walker.sv
// Hardware page-table walker: resolves a TLB miss by walking an NLEVEL radix table
// through a single-outstanding PTE read port, then pulses insert (translation) or fault.
module page_walker #(
  parameter int SADDR  = 64,
  parameter int SPAGE  = 12,
  parameter int SPCID  = 12,
  parameter int NLEVEL = 4,
  parameter int SIDX   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss_valid,
  output logic             miss_ready,
  input  logic [SADDR-1:0] miss_va,
  input  logic [SPCID-1:0] miss_pcid,
  input  logic [SADDR-1:0] root_pa,
  input  logic             shutdown,
  page_walker_if.master    mem,
  output logic             insert,
  output logic [SADDR-1:0] ins_va,
  output logic [SADDR-1:0] ins_pa,
  output logic [SPCID-1:0] ins_pcid,
  output logic             fault,
  output logic [SADDR-1:0] fault_va,
  output logic             busy
);

  localparam int LW = (NLEVEL > 1) ? $clog2(NLEVEL) : 1;
  localparam logic [LW-1:0] TOP_LEVEL = LW'(NLEVEL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_FAULT,
    S_DRAIN
  } state_t;

  state_t           state_reg;
  logic [LW-1:0]    level_reg;
  logic [SADDR-1:0] va_reg;
  logic [SPCID-1:0] pcid_reg;
  logic             miss_ready_reg;
  logic             busy_reg;
  logic             req_valid_reg;
  logic [SADDR-1:0] req_addr_reg;
  logic             insert_reg;
  logic             fault_reg;
  logic [SADDR-1:0] ins_va_reg;
  logic [SADDR-1:0] ins_pa_reg;
  logic [SPCID-1:0] ins_pcid_reg;
  logic [SADDR-1:0] fault_va_reg;

  // Per-level table index fields of the latched VA.
  logic [SIDX-1:0]  va_idx [NLEVEL];
  logic [SIDX-1:0]  miss_top_idx;
  logic [SIDX-1:0]  lower_idx;
  logic [SADDR-1:0] pte_base;
  logic             pte_present;
  logic             unused_pte_bits;

  genvar gi;
  generate
    for (gi = 0; gi < NLEVEL; gi = gi + 1) begin : g_va_idx
      assign va_idx[gi] = va_reg[SPAGE + SIDX*gi +: SIDX];
    end
  endgenerate

  assign miss_top_idx    = miss_va[SPAGE + SIDX*(NLEVEL-1) +: SIDX];
  assign lower_idx       = va_idx[level_reg - 1'b1];
  assign pte_base        = {mem.mem_resp_data[SADDR-1:SPAGE], {SPAGE{1'b0}}};
  assign pte_present     = mem.mem_resp_data[0];
  // Permission/attribute bits of the PTE play no part in the walk.
  assign unused_pte_bits = ^mem.mem_resp_data[SPAGE-1:1];

  function automatic logic [SADDR-1:0] pte_offset(input logic [SIDX-1:0] idx);
    return SADDR'({idx, 3'b000});
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      level_reg      <= TOP_LEVEL;
      va_reg         <= '0;
      pcid_reg       <= '0;
      miss_ready_reg <= 1'b1;
      busy_reg       <= 1'b0;
      req_valid_reg  <= 1'b0;
      req_addr_reg   <= '0;
      insert_reg     <= 1'b0;
      fault_reg      <= 1'b0;
      ins_va_reg     <= '0;
      ins_pa_reg     <= '0;
      ins_pcid_reg   <= '0;
      fault_va_reg   <= '0;
    end else begin
      insert_reg <= 1'b0;
      fault_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (miss_valid) begin
            va_reg         <= miss_va;
            pcid_reg       <= miss_pcid;
            level_reg      <= TOP_LEVEL;
            req_addr_reg   <= root_pa + pte_offset(miss_top_idx);
            req_valid_reg  <= 1'b1;
            miss_ready_reg <= 1'b0;
            busy_reg       <= 1'b1;
            state_reg      <= S_REQ;
          end
        end

        S_REQ: begin
          if (mem.mem_req_ready) begin
            // Once the request is accepted its response must be absorbed, even if aborted.
            req_valid_reg <= 1'b0;
            state_reg     <= shutdown ? S_DRAIN : S_WAIT;
          end else if (shutdown) begin
            req_valid_reg  <= 1'b0;
            miss_ready_reg <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= S_IDLE;
          end
        end

        S_WAIT: begin
          if (shutdown) begin
            if (mem.mem_resp_valid) begin
              miss_ready_reg <= 1'b1;
              busy_reg       <= 1'b0;
              state_reg      <= S_IDLE;
            end else begin
              state_reg <= S_DRAIN;
            end
          end else if (mem.mem_resp_valid) begin
            if (!pte_present) begin
              fault_reg    <= 1'b1;
              fault_va_reg <= va_reg;
              state_reg    <= S_FAULT;
            end else if (level_reg != '0) begin
              level_reg     <= level_reg - 1'b1;
              req_addr_reg  <= pte_base + pte_offset(lower_idx);
              req_valid_reg <= 1'b1;
              state_reg     <= S_REQ;
            end else begin
              insert_reg   <= 1'b1;
              ins_va_reg   <= va_reg;
              ins_pa_reg   <= pte_base;
              ins_pcid_reg <= pcid_reg;
              state_reg    <= S_DONE;
            end
          end
        end

        S_DONE, S_FAULT: begin
          miss_ready_reg <= 1'b1;
          busy_reg       <= 1'b0;
          state_reg      <= S_IDLE;
        end

        S_DRAIN: begin
          if (mem.mem_resp_valid) begin
            miss_ready_reg <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= S_IDLE;
          end
        end

        default: begin
          req_valid_reg  <= 1'b0;
          miss_ready_reg <= 1'b1;
          busy_reg       <= 1'b0;
          state_reg      <= S_IDLE;
        end
      endcase
    end
  end

  assign miss_ready        = miss_ready_reg;
  assign busy              = busy_reg;
  assign mem.mem_req_valid = req_valid_reg;
  assign mem.mem_req_addr  = req_addr_reg;
  assign insert            = insert_reg;
  assign ins_va            = ins_va_reg;
  assign ins_pa            = ins_pa_reg;
  assign ins_pcid          = ins_pcid_reg;
  assign fault             = fault_reg;
  assign fault_va          = fault_va_reg;

endmodule

// File: tb/tb_page_walker.sv
// Self-checking bench for page_walker: directed walks (latency, fault, backpressure,
// shutdown, reset, back-to-back) plus randomized walks against a table-lookup model.
module tb_page_walker;
  localparam int SADDR  = 64;
  localparam int SPAGE  = 12;
  localparam int SPCID  = 12;
  localparam int NLEVEL = 4;
  localparam int SIDX   = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid;
  logic        miss_ready;
  logic [63:0] miss_va;
  logic [11:0] miss_pcid;
  logic [63:0] root_pa;
  logic        shutdown;
  logic        insert;
  logic [63:0] ins_va;
  logic [63:0] ins_pa;
  logic [11:0] ins_pcid;
  logic        fault;
  logic [63:0] fault_va;
  logic        busy;

  always #5 clk = ~clk;

  page_walker_if #(.SADDR(SADDR)) mem_if ();

  page_walker #(
    .SADDR(SADDR), .SPAGE(SPAGE), .SPCID(SPCID), .NLEVEL(NLEVEL), .SIDX(SIDX)
  ) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_va(miss_va), .miss_pcid(miss_pcid), .root_pa(root_pa),
    .shutdown(shutdown), .mem(mem_if),
    .insert(insert), .ins_va(ins_va), .ins_pa(ins_pa), .ins_pcid(ins_pcid),
    .fault(fault), .fault_va(fault_va), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // Page-table memory contents; absent entries read as zero (non-present).
  logic [63:0] pt [logic [63:0]];

  function automatic logic [63:0] pte_at(input logic [63:0] addr);
    return pt.exists(addr) ? pt[addr] : 64'h0;
  endfunction

  // Memory responder state
  bit          pending   = 0;
  int          resp_cnt  = 0;
  logic [63:0] pend_data = 0;
  int          req_cnt   = 0;
  bit          rand_mode = 0;
  int          slow_idx  = -1;
  int          slow_dly  = 1;
  int          stall_idx = -1;
  int          stall_left = 0;
  logic [63:0] got_addrs[$];
  logic [63:0] stall_addrs[$];

  initial begin
    int d;
    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_resp_valid = 1'b0;
    mem_if.mem_resp_data  = 64'h0;
    forever begin
      @(negedge clk);
      mem_if.mem_resp_valid = 1'b0;
      if (pending) begin
        if (resp_cnt == 0) begin
          mem_if.mem_resp_valid = 1'b1;
          mem_if.mem_resp_data  = pend_data;
          pending = 0;
        end else begin
          resp_cnt--;
        end
      end
      if (stall_left > 0 && mem_if.mem_req_valid && req_cnt == stall_idx) begin
        mem_if.mem_req_ready = 1'b0;
        stall_addrs.push_back(mem_if.mem_req_addr);
        stall_left--;
      end else begin
        mem_if.mem_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (mem_if.mem_req_valid && mem_if.mem_req_ready) begin
        got_addrs.push_back(mem_if.mem_req_addr);
        pend_data = pte_at(mem_if.mem_req_addr);
        d = (req_cnt == slow_idx) ? slow_dly : (rand_mode ? int'($urandom_range(1, 3)) : 1);
        resp_cnt = d - 1;
        pending  = 1;
        req_cnt++;
      end
    end
  end

  // Reference model: plain radix-table lookup from the architectural rules.
  logic [63:0] exp_addrs[$];
  logic [63:0] last_va   = 0;
  logic [63:0] last_pa   = 0;
  logic [11:0] last_pcid = 0;

  task automatic model_walk(input logic [63:0] va, input logic [63:0] root,
                            output bit flt, output logic [63:0] pa);
    logic [63:0] base;
    logic [63:0] addr;
    logic [63:0] pte;
    exp_addrs.delete();
    base = root;
    flt  = 0;
    for (int l = NLEVEL - 1; l >= 0; l--) begin
      addr = base + 64'd8 * ((va >> (SPAGE + SIDX * l)) & 64'h1FF);
      exp_addrs.push_back(addr);
      pte = pte_at(addr);
      if (pte[0] == 1'b0) begin
        flt = 1;
        break;
      end
      base = pte & ~64'hFFF;
    end
    pa = base;
  endtask

  // Builds a random chain of tables for va; may terminate early with a non-present PTE.
  task automatic populate(input logic [63:0] va, input logic [63:0] root);
    logic [63:0] base;
    logic [63:0] addr;
    logic [63:0] pte;
    base = root;
    for (int l = NLEVEL - 1; l >= 0; l--) begin
      addr = base + 64'd8 * ((va >> (SPAGE + SIDX * l)) & 64'h1FF);
      if (!pt.exists(addr)) begin
        pte = (64'($urandom) << 12) | (64'($urandom_range(0, 2047)) << 1);
        pte[0] = ($urandom_range(0, 99) < 88);
        pt[addr] = pte;
      end
      pte = pt[addr];
      if (pte[0] == 1'b0) break;
      base = pte & ~64'hFFF;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_miss(input logic [63:0] va, input logic [11:0] pcid,
                            input logic [63:0] root, output int t);
    int n;
    n = 0;
    got_addrs.delete();
    req_cnt    = 0;
    miss_valid = 1'b1;
    miss_va    = va;
    miss_pcid  = pcid;
    root_pa    = root;
    while (!miss_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", miss_ready, 1'b1);
    t = cyc;
    @(negedge clk);
  endtask

  // extra < 0 skips the latency check; otherwise pulse is expected at t + 2*nreq + 1 + extra.
  task automatic finish_walk(input logic [63:0] va, input logic [11:0] pcid,
                             input logic [63:0] root, input int t, input int extra,
                             input string tag);
    bit          flt;
    logic [63:0] pa;
    int          n;
    model_walk(va, root, flt, pa);
    n = 0;
    while (!(insert || fault) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pulse"}, insert | fault, 1'b1);
    if (insert || fault) begin
      check({tag, "_insert"}, insert, !flt);
      check({tag, "_fault"}, fault, flt);
      if (extra >= 0) check({tag, "_latency"}, cyc - t, 2 * exp_addrs.size() + 1 + extra);
      if (flt) begin
        check({tag, "_fault_va"}, fault_va, va);
        check({tag, "_ins_va_hold"}, ins_va, last_va);
        check({tag, "_ins_pa_hold"}, ins_pa, last_pa);
        check({tag, "_ins_pcid_hold"}, ins_pcid, last_pcid);
      end else begin
        check({tag, "_ins_va"}, ins_va, va);
        check({tag, "_ins_pa"}, ins_pa, pa);
        check({tag, "_ins_pcid"}, ins_pcid, pcid);
        last_va   = va;
        last_pa   = pa;
        last_pcid = pcid;
      end
    end
    check({tag, "_nreq"}, got_addrs.size(), exp_addrs.size());
    for (int i = 0; i < exp_addrs.size() && i < got_addrs.size(); i++)
      check({tag, "_req_addr"}, got_addrs[i], exp_addrs[i]);
    $display("walk %s va=%h pcid=%h -> %s pa=%h reqs=%0d", tag, va, pcid,
             flt ? "fault" : "insert", pa, got_addrs.size());
    @(negedge clk);
    check({tag, "_pulse_end"}, insert | fault, 1'b0);
    check({tag, "_idle_ready"}, miss_ready, 1'b1);
  endtask

  localparam logic [63:0] VA1 = 64'h0000_0080_4020_1ABC;

  initial begin
    int          t;
    int          t2;
    int          pulses;
    logic [63:0] va;
    logic [63:0] root;
    logic [11:0] pcid;

    rst = 1'b1; miss_valid = 1'b0; miss_va = 0; miss_pcid = 0; root_pa = 0; shutdown = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_insert", insert, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", miss_ready, 1'b1);
    check("rst_req_valid", mem_if.mem_req_valid, 1'b0);
    check("rst_req_addr", mem_if.mem_req_addr, 64'h0);
    check("rst_ins_va", ins_va, 64'h0);
    check("rst_ins_pa", ins_pa, 64'h0);
    check("rst_ins_pcid", ins_pcid, 12'h0);
    check("rst_fault_va", fault_va, 64'h0);
    rst = 1'b0;

    pt[64'h1008] = 64'h2001;
    pt[64'h2008] = 64'h3001;
    pt[64'h3008] = 64'h4001;
    pt[64'h4008] = 64'h5_5000_0001;

    // Full walk with fixed latency
    start_miss(VA1, 12'h05A, 64'h1000, t);
    check("full_first_req_valid", mem_if.mem_req_valid, 1'b1);
    check("full_first_req_addr", mem_if.mem_req_addr, 64'h1008);
    miss_valid = 1'b0;
    finish_walk(VA1, 12'h05A, 64'h1000, t, 0, "full");
    check("full_pa_const", ins_pa, 64'h5_5000_0000);

    // Fault at level 2
    pt[64'h2008] = 64'h3000;
    start_miss(VA1, 12'h0A5, 64'h1000, t);
    miss_valid = 1'b0;
    finish_walk(VA1, 12'h0A5, 64'h1000, t, 0, "fault");
    pt[64'h2008] = 64'h3001;

    // Backpressure on the level-2 request
    stall_addrs.delete();
    stall_idx = 1; stall_left = 3;
    start_miss(VA1, 12'h05A, 64'h1000, t);
    miss_valid = 1'b0;
    finish_walk(VA1, 12'h05A, 64'h1000, t, 3, "bp");
    check("bp_stall_cycles", stall_addrs.size(), 3);
    foreach (stall_addrs[i]) check("bp_held_addr", stall_addrs[i], 64'h2008);
    stall_idx = -1;

    // Shutdown while waiting at level 1; response arrives two cycles later
    slow_idx = 2; slow_dly = 3;
    start_miss(VA1, 12'h05A, 64'h1000, t);
    miss_valid = 1'b0;
    pulses = 0;
    while (cyc < t + 6) begin
      pulses += int'(insert) + int'(fault);
      @(negedge clk);
    end
    shutdown = 1'b1;
    @(negedge clk);
    shutdown = 1'b0;
    while (cyc < t + 8) begin
      pulses += int'(insert) + int'(fault);
      @(negedge clk);
    end
    check("sd_busy_in_drain", busy, 1'b1);
    check("sd_req_valid_drain", mem_if.mem_req_valid, 1'b0);
    @(negedge clk);
    check("sd_ready_after_resp", miss_ready, 1'b1);
    repeat (4) begin
      pulses += int'(insert) + int'(fault);
      @(negedge clk);
    end
    check("sd_no_pulse", pulses, 0);
    $display("walk shutdown va=%h aborted pulses=%0d", VA1, pulses);
    slow_idx = -1;
    start_miss(VA1, 12'h011, 64'h1000, t);
    miss_valid = 1'b0;
    finish_walk(VA1, 12'h011, 64'h1000, t, 0, "post_sd");

    // Reset during level-2 wait
    slow_idx = 1; slow_dly = 3;
    start_miss(VA1, 12'h05A, 64'h1000, t);
    miss_valid = 1'b0;
    while (cyc < t + 4) @(negedge clk);
    rst = 1'b1;
    pending = 0;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", busy, 1'b0);
    check("mrst_ready", miss_ready, 1'b1);
    check("mrst_insert", insert, 1'b0);
    check("mrst_fault", fault, 1'b0);
    check("mrst_req_valid", mem_if.mem_req_valid, 1'b0);
    check("mrst_ins_va", ins_va, 64'h0);
    $display("walk reset va=%h aborted by rst", VA1);
    last_va = 0; last_pa = 0; last_pcid = 0;
    slow_idx = -1;
    start_miss(VA1, 12'h077, 64'h1000, t);
    miss_valid = 1'b0;
    finish_walk(VA1, 12'h077, 64'h1000, t, 0, "post_rst");

    // Back-to-back misses with valid held high
    va = 64'hFFFF_0080_4020_1DEF;
    start_miss(VA1, 12'h05A, 64'h1000, t);
    miss_va = va; miss_pcid = 12'h123;
    finish_walk(VA1, 12'h05A, 64'h1000, t, 0, "b2b_first");
    check("b2b_accept_ready", miss_ready & miss_valid, 1'b1);
    t2 = cyc;
    check("b2b_accept_cycle", t2 - t, 10);
    got_addrs.delete();
    req_cnt = 0;
    @(negedge clk);
    miss_valid = 1'b0;
    finish_walk(va, 12'h123, 64'h1000, t2, 0, "b2b_second");

    // Randomized walks with random ready and response delays
    rand_mode = 1;
    for (int k = 0; k < 40; k++) begin
      va   = {$urandom, $urandom};
      pcid = 12'($urandom);
      root = 64'($urandom_range(1, 32'hF_FFFF)) << 12;
      populate(va, root);
      start_miss(va, pcid, root, t);
      miss_valid = 1'b0;
      finish_walk(va, pcid, root, t, -1, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
